// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared types and constants for the 7-segment scanner
//   scan_state_e   : BLANK (all anodes off) / DRIVE (one digit lit)
//   SEG_OFF        : all cathodes off, active-low
//   HEX_SEG_TABLE  : nibble -> {g,f,e,d,c,b,a} active-low segment pattern
//   hex_to_seg()   : table lookup helper
package seven_seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } scan_state_e;

  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Segment order is {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] HEX_SEG_TABLE [16] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000,  // 9
    7'b0001000,  // A
    7'b0000011,  // b
    7'b1000110,  // C
    7'b0100001,  // d
    7'b0000110,  // E
    7'b0001110   // F
  };

  function automatic logic [6:0] hex_to_seg(input logic [3:0] nibble);
    return HEX_SEG_TABLE[nibble];
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// rtl/seg7_decoder.sv - combinational hex nibble to active-low 7-segment decoder
//   nibble  in   4   hex value 0-F
//   seg     out  7   cathodes {g,f,e,d,c,b,a}, active-low
module seg7_decoder
  import seven_seg_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = hex_to_seg(nibble);
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// rtl/seven_seg_scanner.sv - time-multiplexed multi-digit 7-segment display scanner
//   Optional feature macro: SEVEN_SEG_BLINK_EN (adds blink_mask and per-digit blinking)
//   clk          in   1             system clock, all state on posedge
//   rst_n        in   1             asynchronous active-low reset
//   display_clk  in   1             divided scan clock level; rising edge = scan tick
//   digits       in   4*NUM_DIGITS  hex nibbles, [3:0] = digit 0 (rightmost)
//   dp           in   NUM_DIGITS    decimal point request per digit, active-high
//   blink_mask   in   NUM_DIGITS    per-digit blink enable (SEVEN_SEG_BLINK_EN only)
//   an           out  NUM_DIGITS    anodes, active-low, at most one low
//   seg          out  7             cathodes {g,f,e,d,c,b,a}, active-low
//   seg_dp       out  1             decimal point cathode, active-low
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int BLANK_TICKS = 1,
  parameter int BLINK_TICKS = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    display_clk,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
`ifdef SEVEN_SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask,
`endif
  output logic [NUM_DIGITS-1:0]   an,
  output logic [6:0]              seg,
  output logic                    seg_dp
);

  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCNT_W = (BLANK_TICKS > 1) ? $clog2(BLANK_TICKS) : 1;

  localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BCNT_W-1:0] BLANK_LAST = BCNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);

`ifdef SEVEN_SEG_BLINK_EN
  localparam int BLCNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;
  localparam logic [BLCNT_W-1:0] BLINK_LAST = BLCNT_W'((BLINK_TICKS > 0) ? BLINK_TICKS - 1 : 0);
`endif

  scan_state_e             state_q, state_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [BCNT_W-1:0]       blank_cnt_q, blank_cnt_d;
  logic [4*NUM_DIGITS-1:0] snap_digits_q, snap_digits_d;
  logic [NUM_DIGITS-1:0]   snap_dp_q, snap_dp_d;
  logic                    disp_hist_q, disp_hist_d;
  logic                    armed_q, armed_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              seg_q, seg_d;
  logic                    seg_dp_q, seg_dp_d;
`ifdef SEVEN_SEG_BLINK_EN
  logic [BLCNT_W-1:0]      blink_cnt_q, blink_cnt_d;
  logic                    phase_q, phase_d;
  logic [NUM_DIGITS-1:0]   snap_blink_q, snap_blink_d;
`endif

  logic       tick;
  logic       load_snap;
  logic       slot_dark;
  logic [3:0] sel_nibble;
  logic [6:0] dec_seg;

  // Decode the nibble the slot will show after this edge, so the
  // registered outputs carry a freshly loaded snapshot with no extra cycle.
  seg7_decoder u_decoder (
    .nibble (sel_nibble),
    .seg    (dec_seg)
  );

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    blank_cnt_d   = blank_cnt_q;
    snap_digits_d = snap_digits_q;
    snap_dp_d     = snap_dp_q;
    an_d          = an_q;
    seg_d         = seg_q;
    seg_dp_d      = seg_dp_q;
    slot_dark     = 1'b0;
`ifdef SEVEN_SEG_BLINK_EN
    blink_cnt_d   = blink_cnt_q;
    phase_d       = phase_q;
    snap_blink_d  = snap_blink_q;
`endif

    // armed_q masks the first cycle after reset so a display_clk that is
    // already high at release (history reset to 0) is not taken as an edge.
    disp_hist_d = display_clk;
    armed_d     = 1'b1;
    tick        = display_clk & ~disp_hist_q & armed_q;

    if (tick) begin
      unique case (state_q)
        BLANK: begin
          if ((BLANK_TICKS == 0) || (blank_cnt_q == BLANK_LAST)) begin
            state_d     = DRIVE;
            blank_cnt_d = '0;
          end else begin
            blank_cnt_d = blank_cnt_q + 1'b1;
          end
        end
        DRIVE: begin
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
          if (BLANK_TICKS != 0) begin
            state_d = BLANK;
          end
        end
        default: state_d = BLANK;
      endcase
    end

    // A new frame starts whenever digit 0 is about to be lit.
    load_snap = tick && (state_d == DRIVE) && (idx_d == '0);
    if (load_snap) begin
      snap_digits_d = digits;
      snap_dp_d     = dp;
`ifdef SEVEN_SEG_BLINK_EN
      snap_blink_d  = blink_mask;
`endif
    end

`ifdef SEVEN_SEG_BLINK_EN
    if (tick) begin
      if (blink_cnt_q == BLINK_LAST) begin
        blink_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        blink_cnt_d = blink_cnt_q + 1'b1;
      end
    end
    // The phase in force when the tick arrives decides the slot.
    slot_dark = phase_q & snap_blink_d[idx_d];
`endif

    sel_nibble = snap_digits_d[4*int'(idx_d) +: 4];

    if (tick) begin
      an_d     = '1;
      seg_d    = SEG_OFF;
      seg_dp_d = 1'b1;
      if ((state_d == DRIVE) && !slot_dark) begin
        an_d     = ~(NUM_DIGITS'(1) << idx_d);
        seg_d    = dec_seg;
        seg_dp_d = ~snap_dp_d[idx_d];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= BLANK;
      idx_q         <= '0;
      blank_cnt_q   <= '0;
      snap_digits_q <= '0;
      snap_dp_q     <= '0;
      disp_hist_q   <= 1'b0;
      armed_q       <= 1'b0;
      an_q          <= '1;
      seg_q         <= SEG_OFF;
      seg_dp_q      <= 1'b1;
`ifdef SEVEN_SEG_BLINK_EN
      blink_cnt_q   <= '0;
      phase_q       <= 1'b0;
      snap_blink_q  <= '0;
`endif
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      blank_cnt_q   <= blank_cnt_d;
      snap_digits_q <= snap_digits_d;
      snap_dp_q     <= snap_dp_d;
      disp_hist_q   <= disp_hist_d;
      armed_q       <= armed_d;
      an_q          <= an_d;
      seg_q         <= seg_d;
      seg_dp_q      <= seg_dp_d;
`ifdef SEVEN_SEG_BLINK_EN
      blink_cnt_q   <= blink_cnt_d;
      phase_q       <= phase_d;
      snap_blink_q  <= snap_blink_d;
`endif
    end
  end

  assign an     = an_q;
  assign seg    = seg_q;
  assign seg_dp = seg_dp_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// tb/tb_seven_seg_scanner.sv - directed self-checking bench for seven_seg_scanner
module tb_seven_seg_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        display_clk;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic        seg_dp_a, seg_dp_b;
`ifdef SEVEN_SEG_BLINK_EN
  logic [3:0]  blink_mask;
  logic [3:0]  no_blink;
  logic [3:0]  an_c;
  logic [6:0]  seg_c;
  logic        seg_dp_c;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seven_seg_scanner #(.NUM_DIGITS(4), .BLANK_TICKS(1), .BLINK_TICKS(64)) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .display_clk (display_clk),
    .digits      (digits),
    .dp          (dp),
`ifdef SEVEN_SEG_BLINK_EN
    .blink_mask  (no_blink),
`endif
    .an          (an_a),
    .seg         (seg_a),
    .seg_dp      (seg_dp_a)
  );

  seven_seg_scanner #(.NUM_DIGITS(4), .BLANK_TICKS(0), .BLINK_TICKS(64)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .display_clk (display_clk),
    .digits      (digits),
    .dp          (dp),
`ifdef SEVEN_SEG_BLINK_EN
    .blink_mask  (no_blink),
`endif
    .an          (an_b),
    .seg         (seg_b),
    .seg_dp      (seg_dp_b)
  );

`ifdef SEVEN_SEG_BLINK_EN
  seven_seg_scanner #(.NUM_DIGITS(4), .BLANK_TICKS(0), .BLINK_TICKS(4)) u_dut_c (
    .clk         (clk),
    .rst_n       (rst_n),
    .display_clk (display_clk),
    .digits      (digits),
    .dp          (dp),
    .blink_mask  (blink_mask),
    .an          (an_c),
    .seg         (seg_c),
    .seg_dp      (seg_dp_c)
  );
`endif

  // Ticks 1..23; inputs switch from 1234/dp=0 to ABCD/dp=0100 after tick 13.
  logic [3:0] a_an  [23] = '{4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF,
                             4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7, 4'hF,
                             4'hE, 4'hF, 4'hD, 4'hF, 4'hB, 4'hF, 4'h7};
  logic [6:0] a_seg [23] = '{7'h19, 7'h7F, 7'h30, 7'h7F, 7'h24, 7'h7F, 7'h79, 7'h7F,
                             7'h19, 7'h7F, 7'h30, 7'h7F, 7'h24, 7'h7F, 7'h79, 7'h7F,
                             7'h21, 7'h7F, 7'h46, 7'h7F, 7'h03, 7'h7F, 7'h08};
  logic       a_dp  [23] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
                             1, 1, 1, 1, 0, 1, 1};
  logic [3:0] b_an  [23] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7,
                             4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB, 4'h7,
                             4'hE, 4'hD, 4'hB, 4'h7, 4'hE, 4'hD, 4'hB};
  logic [6:0] b_seg [23] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h19, 7'h30, 7'h24, 7'h79,
                             7'h19, 7'h30, 7'h24, 7'h79, 7'h19, 7'h30, 7'h24, 7'h79,
                             7'h21, 7'h46, 7'h03, 7'h08, 7'h21, 7'h46, 7'h03};
  logic       b_dp  [23] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1,
                             1, 1, 0, 1, 1, 1, 0};

  task automatic check_eq(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising display_clk edge; outputs are sampled on the negedge after
  // the posedge that consumed it.
  task automatic scan_tick();
    @(negedge clk);
    display_clk = 1'b1;
    @(negedge clk);
    display_clk = 1'b0;
    @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, " an_a"},   16'(an_a),     16'hF);
    check_eq({tag, " seg_a"},  16'(seg_a),    16'h7F);
    check_eq({tag, " dp_a"},   16'(seg_dp_a), 16'h1);
    check_eq({tag, " an_b"},   16'(an_b),     16'hF);
  endtask

  initial begin
    rst_n       = 1'b0;
    display_clk = 1'b0;
    digits      = 16'h1234;
    dp          = 4'b0000;
`ifdef SEVEN_SEG_BLINK_EN
    blink_mask  = 4'b0001;
    no_blink    = 4'b0000;
`endif

    // Reset held while display_clk toggles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      display_clk = 1'b1;
      @(negedge clk);
      check_reset_outputs($sformatf("rst_hold_hi%0d", i));
      display_clk = 1'b0;
      @(negedge clk);
      check_reset_outputs($sformatf("rst_hold_lo%0d", i));
    end

    // Release with display_clk already high: no tick may result.
    display_clk = 1'b1;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    check_reset_outputs("no_tick_release");
    display_clk = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("idle_low");

    // Scan, mid-frame input change, dp, and zero-blank walk.
    for (int t = 0; t < 23; t++) begin
      scan_tick();
      check_eq($sformatf("a_an t%0d", t + 1),  16'(an_a),     16'(a_an[t]));
      check_eq($sformatf("a_seg t%0d", t + 1), 16'(seg_a),    16'(a_seg[t]));
      check_eq($sformatf("a_dp t%0d", t + 1),  16'(seg_dp_a), 16'(a_dp[t]));
      check_eq($sformatf("b_an t%0d", t + 1),  16'(an_b),     16'(b_an[t]));
      check_eq($sformatf("b_seg t%0d", t + 1), 16'(seg_b),    16'(b_seg[t]));
      check_eq($sformatf("b_dp t%0d", t + 1),  16'(seg_dp_b), 16'(b_dp[t]));
`ifdef SEVEN_SEG_BLINK_EN
      // Digit 0 slots at ticks 5, 13, 21 fall in the blink-off phase.
      check_eq($sformatf("c_an t%0d", t + 1), 16'(an_c),
               ((t + 1) % 8 == 5) ? 16'hF : 16'(b_an[t]));
      check_eq($sformatf("c_seg t%0d", t + 1), 16'(seg_c),
               ((t + 1) % 8 == 5) ? 16'h7F : 16'(b_seg[t]));
`endif
      if (t == 12) begin
        digits = 16'hABCD;
        dp     = 4'b0100;
      end
    end

    // Advance A to its digit 2 slot, then reset asynchronously mid-scan.
    repeat (6) scan_tick();
    check_eq("pre_rst a_an", 16'(an_a), 16'hB);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst_idle");
    scan_tick();
    check_eq("resume a_an",  16'(an_a),  16'hE);
    check_eq("resume a_seg", 16'(seg_a), 16'h21);
    check_eq("resume b_an",  16'(an_b),  16'hE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
